// File: rtl/uart_stream_tx.sv
// uart_stream_tx: streams a block of bytes from a synchronous buffer RAM into a
// UART transmitter. Flow control comes from the host RTS line. The block also
// provides start/stop control, a programmable length, loop mode, done/abort
// status and a count of sent bytes.
module uart_stream_tx #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic                  rts_n,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  uart_transmit,
  output logic [DATA_WIDTH-1:0] uart_tx_byte,
  input  logic                  uart_is_transmitting,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [CNT_WIDTH-1:0]  byte_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CTS,
    S_READ,
    S_LOAD,
    S_WAIT_BSY,
    S_WAIT_IDL
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_last;
  logic                  r_loop;
  logic                  r_stop_req;
  logic                  r_rts_s1;
  logic                  r_rts_s2;
  logic                  r_transmit;
  logic [DATA_WIDTH-1:0] r_tx_byte;
  logic                  r_done;
  logic                  r_aborted;
  logic [CNT_WIDTH-1:0]  r_count;

  logic                  w_cts;
  logic                  w_at_last;

  assign w_cts     = ~r_rts_s2;
  assign w_at_last = (r_addr == r_last);

  assign ram_addr      = r_addr;
  assign uart_transmit = r_transmit;
  assign uart_tx_byte  = r_tx_byte;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign aborted       = r_aborted;
  assign byte_count    = r_count;

  // Two-flop synchronizer for the asynchronous host RTS line. It resets to "not ready".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rts_s1 <= 1'b1;
      r_rts_s2 <= 1'b1;
    end else begin
      r_rts_s1 <= rts_n;
      r_rts_s2 <= r_rts_s1;
    end
  end

  // Streaming FSM. It owns the address counter, the UART handshake and the status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_last     <= '0;
      r_loop     <= 1'b0;
      r_stop_req <= 1'b0;
      r_transmit <= 1'b0;
      r_tx_byte  <= '0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_count    <= '0;
    end else begin
      r_transmit <= 1'b0;
      r_done     <= 1'b0;
      // A stop is remembered until the next byte boundary. The IDLE entries
      // below clear it again because they are assigned later in this block.
      if (stop && (r_state != S_IDLE)) r_stop_req <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_last    <= last_addr;
            r_loop    <= loop_en;
            r_addr    <= '0;
            r_count   <= '0;
            r_aborted <= 1'b0;
            r_state   <= S_WAIT_CTS;
          end
        end
        S_WAIT_CTS: begin
          if (r_stop_req) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b1;
            r_aborted  <= 1'b1;
            r_stop_req <= 1'b0;
          end else if (w_cts) begin
            r_state <= S_READ;
          end
        end
        S_READ: r_state <= S_LOAD;
        S_LOAD: begin
          r_tx_byte  <= ram_rdata;
          r_transmit <= 1'b1;
          r_state    <= S_WAIT_BSY;
        end
        S_WAIT_BSY: begin
          if (uart_is_transmitting) r_state <= S_WAIT_IDL;
        end
        S_WAIT_IDL: begin
          if (!uart_is_transmitting) begin
            r_count <= r_count + 1'b1;
            if (!w_at_last) begin
              r_addr  <= r_addr + 1'b1;
              r_state <= S_WAIT_CTS;
            end else if (r_loop && !r_stop_req) begin
              r_addr  <= '0;
              r_state <= S_WAIT_CTS;
            end else begin
              r_state    <= S_IDLE;
              r_done     <= 1'b1;
              r_aborted  <= r_stop_req;
              r_stop_req <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_stream_tx.sv
// Testbench for uart_stream_tx. It uses a behavioural RAM and UART, a scoreboard
// of expected bytes, and a monitor that checks every uart_transmit request.
module tb_uart_stream_tx;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic          rts_n = 1'b1;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata = '0;
  logic          uart_transmit;
  logic [DW-1:0] uart_tx_byte;
  logic          uart_is_transmitting = 1'b0;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [CW-1:0] byte_count;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] sb_q[$];
  int            n_checks = 0;
  int            n_err = 0;
  int            n_tx = 0;
  int            n_done = 0;
  bit            in_rst_test = 1'b0;

  uart_stream_tx #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .last_addr(last_addr), .rts_n(rts_n), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting), .busy(busy), .done(done),
    .aborted(aborted), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read buffer RAM
  always @(posedge clk) ram_rdata <= mem[ram_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every transmit request must carry the next expected byte
  always @(negedge clk) begin
    if (rst_n && uart_transmit) begin
      n_tx++;
      if (sb_q.size() == 0) check("unexpected_tx", 32'(uart_tx_byte), 32'hFFFF_FFFF);
      else check("tx_byte", 32'(uart_tx_byte), 32'(sb_q.pop_front()));
    end
    if (rst_n && done) n_done++;
  end

  // Behavioural UART: goes busy shortly after a request and idles again after a random time
  initial begin
    logic [DW-1:0] b;
    bit stable;
    forever begin
      @(negedge clk);
      if (rst_n && uart_transmit) begin
        b = uart_tx_byte;
        stable = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        uart_is_transmitting = 1'b1;
        repeat ($urandom_range(3, 6)) begin
          @(negedge clk);
          if (uart_tx_byte !== b) stable = 1'b0;
        end
        if (!in_rst_test) check("tx_byte_stable", 32'(stable), 32'd1);
        uart_is_transmitting = 1'b0;
      end
    end
  end

  // Reference model: stream byte i is mem[i mod length]
  task automatic push_expected(input int last, input int count);
    for (int i = 0; i < count; i++) sb_q.push_back(mem[i % (last + 1)]);
  endtask

  task automatic do_start(input int last, input bit lp);
    @(posedge clk); #1;
    last_addr = AW'(last);
    loop_en = lp;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    loop_en = 1'b0;
    last_addr = '0;
  endtask

  task automatic wait_done(input int max, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_tx(input int target, input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (n_tx >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_tx_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    int base;
    int dn;
    int lat;
    int lst;

    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_transmit", 32'(uart_transmit), 0);
    check("rst_tx_byte", 32'(uart_tx_byte), 0);
    check("rst_done", 32'(done), 0);
    check("rst_aborted", 32'(aborted), 0);
    check("rst_count", 32'(byte_count), 0);
    check("rst_addr", 32'(ram_addr), 0);
    rst_n = 1'b1;

    // 1: four bytes with RTS ready and a check of the start latency
    rts_n = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = DW'(8'hA0 + i);
    repeat (4) @(posedge clk);
    base = n_tx;
    dn = n_done;
    push_expected(3, 4);
    do_start(3, 1'b0);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (uart_transmit) begin
        lat = i;
        break;
      end
    end
    // 3 edges after start is sampled, i.e. 4 cycles from the start pulse
    check("start_latency", 32'(lat), 3);
    wait_done(500, "t1_done");
    check("t1_aborted", 32'(aborted), 0);
    check("t1_count", 32'(byte_count), 4);
    check("t1_busy_falls", 32'(busy), 0);
    check("t1_ntx", 32'(n_tx - base), 4);
    repeat (5) @(negedge clk);
    check("t1_done_once", 32'(n_done - dn), 1);
    check("t1_sb_empty", 32'(sb_q.size()), 0);

    // 2: RTS not ready blocks the stream until it is synchronised
    rts_n = 1'b1;
    repeat (4) @(posedge clk);
    base = n_tx;
    push_expected(1, 2);
    do_start(1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("t2_no_tx_blocked", 32'(n_tx - base), 0);
    check("t2_busy_blocked", 32'(busy), 1);
    rts_n = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (uart_transmit) begin
        lat = i;
        break;
      end
    end
    // 2 synchroniser edges, then WAIT_CTS, READ, LOAD
    check("t2_cts_latency", 32'(lat), 5);
    wait_done(500, "t2_done");
    check("t2_count", 32'(byte_count), 2);

    // 3: loop mode, stopped during the third byte
    mem[0] = 8'h55;
    mem[1] = 8'hAA;
    base = n_tx;
    push_expected(1, 8);
    do_start(1, 1'b1);
    wait_tx(base + 3, 500);
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_done(500, "t3_done");
    check("t3_aborted", 32'(aborted), 1);
    check("t3_count", 32'(byte_count), 3);
    check("t3_ntx", 32'(n_tx - base), 3);
    sb_q.delete();

    // 4: single-byte block
    base = n_tx;
    push_expected(0, 1);
    do_start(0, 1'b0);
    wait_done(500, "t4_done");
    check("t4_count", 32'(byte_count), 1);
    check("t4_ntx", 32'(n_tx - base), 1);
    check("t4_aborted_cleared", 32'(aborted), 0);

    // 5: RTS withdrawn during byte 2 holds byte 3
    for (int i = 0; i < 4; i++) mem[i] = DW'($urandom);
    base = n_tx;
    push_expected(3, 4);
    do_start(3, 1'b0);
    wait_tx(base + 2, 500);
    @(posedge clk); #1;
    rts_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("t5_held", 32'(n_tx - base), 2);
    check("t5_count_held", 32'(byte_count), 2);
    rts_n = 1'b0;
    wait_done(500, "t5_done");
    check("t5_ntx", 32'(n_tx - base), 4);
    check("t5_count", 32'(byte_count), 4);

    // 6a: start while busy is ignored
    base = n_tx;
    push_expected(3, 4);
    do_start(3, 1'b0);
    wait_tx(base + 2, 500);
    do_start(0, 1'b1);
    wait_done(500, "t6_done");
    check("t6_no_restart_ntx", 32'(n_tx - base), 4);
    check("t6_no_restart_count", 32'(byte_count), 4);

    // 6b: reset in the middle of a byte
    base = n_tx;
    push_expected(5, 6);
    do_start(5, 1'b0);
    wait_tx(base + 2, 500);
    in_rst_test = 1'b1;
    dn = n_done;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_transmit", 32'(uart_transmit), 0);
    check("t6_rst_count", 32'(byte_count), 0);
    check("t6_rst_addr", 32'(ram_addr), 0);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("t6_rst_no_done", 32'(n_done - dn), 0);
    check("t6_rst_no_tx", 32'(n_tx - base), 2);
    sb_q.delete();
    in_rst_test = 1'b0;

    // Random block lengths and contents
    for (int k = 0; k < 6; k++) begin
      lst = $urandom_range(0, 9);
      for (int i = 0; i <= lst; i++) mem[i] = DW'($urandom);
      base = n_tx;
      push_expected(lst, lst + 1);
      do_start(lst, 1'b0);
      wait_done(2000, "rnd_done");
      check("rnd_count", 32'(byte_count), 32'(lst + 1));
      check("rnd_ntx", 32'(n_tx - base), 32'(lst + 1));
    end

    // Full RAM block (last_addr all ones)
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    base = n_tx;
    push_expected((1 << AW) - 1, 1 << AW);
    do_start((1 << AW) - 1, 1'b0);
    wait_done(20000, "full_done");
    check("full_count", 32'(byte_count), 32'(1 << AW));
    check("full_ntx", 32'(n_tx - base), 32'(1 << AW));
    check("full_sb_empty", 32'(sb_q.size()), 0);

    repeat (10) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
